pc_fetch_sequencer: RTL and testbench



---
 rtl/pc_fetch_sequencer_if.sv | 36 +++
 rtl/pc_fetch_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Run-control and PC bus between the fetch sequencer (master) and the CPU/bench (slave).
// The error line exists only when PC_FETCH_STALL_WATCHDOG_EN is defined.
interface pc_fetch_sequencer_if;
    logic        start;
    logic        pc_write;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        running;
    logic        done;
    logic [31:0] cycle_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] fetch_cnt;
`ifdef PC_FETCH_STALL_WATCHDOG_EN
    logic        error;

    modport master (
        input  start, pc_write, next_pc,
        output pc, running, done, cycle_cnt, stall_cnt, fetch_cnt, error
    );

    modport slave (
        output start, pc_write, next_pc,
        input  pc, running, done, cycle_cnt, stall_cnt, fetch_cnt, error
    );
`else
    modport master (
        input  start, pc_write, next_pc,
        output pc, running, done, cycle_cnt, stall_cnt, fetch_cnt
    );

    modport slave (
        output start, pc_write, next_pc,
        input  pc, running, done, cycle_cnt, stall_cnt, fetch_cnt
    );
`endif
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC register and run control (IDLE -> RUN -> DRAIN -> HALT) in front of the pipelined CPU.
// Optional stall watchdog enabled by defining PC_FETCH_STALL_WATCHDOG_EN.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] END_PC        = 32'h0000_0100,
    parameter int unsigned DRAIN_CYCLES  = 4,
    parameter int unsigned STALL_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_fetch_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } stateT;

    stateT       state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        running_q, running_d;
    logic        done_q, done_d;
    logic [31:0] cycleCnt_q, cycleCnt_d;
    logic [31:0] stallCnt_q, stallCnt_d;
    logic [31:0] fetchCnt_q, fetchCnt_d;
    logic [3:0]  drainCnt_q, drainCnt_d;
`ifdef PC_FETCH_STALL_WATCHDOG_EN
    logic [7:0]  stallRun_q, stallRun_d;
    logic        error_q, error_d;
`else
    logic        unused_stallTimeout;
    assign unused_stallTimeout = ^8'(STALL_TIMEOUT);
`endif

    // The CPU's PC+4 may carry junk in its low bits; fetch addresses stay word-aligned.
    logic unused_nextPcLsbs;
    assign unused_nextPcLsbs = ^bus.next_pc[1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        running_d  = running_q;
        done_d     = done_q;
        cycleCnt_d = cycleCnt_q;
        stallCnt_d = stallCnt_q;
        fetchCnt_d = fetchCnt_q;
        drainCnt_d = drainCnt_q;
`ifdef PC_FETCH_STALL_WATCHDOG_EN
        stallRun_d = stallRun_q;
        error_d    = error_q;
`endif
        case (state_q)
            IDLE: begin
                pc_d = RESET_PC;
                if (bus.start) begin
                    state_d    = RUN;
                    running_d  = 1'b1;
                    cycleCnt_d = '0;
                    stallCnt_d = '0;
                    fetchCnt_d = '0;
                end
            end
            RUN: begin
                cycleCnt_d = cycleCnt_q + 32'd1;
                if (pc_q == END_PC) begin
                    state_d    = DRAIN;
                    drainCnt_d = 4'(DRAIN_CYCLES);
`ifdef PC_FETCH_STALL_WATCHDOG_EN
                    stallRun_d = '0;
`endif
                end else if (bus.pc_write) begin
                    pc_d       = {bus.next_pc[31:2], 2'b00};
                    fetchCnt_d = fetchCnt_q + 32'd1;
`ifdef PC_FETCH_STALL_WATCHDOG_EN
                    stallRun_d = '0;
`endif
                end else begin
                    stallCnt_d = stallCnt_q + 32'd1;
`ifdef PC_FETCH_STALL_WATCHDOG_EN
                    // The stall that completes the timeout run halts with the error flag set.
                    if (stallRun_q == 8'(STALL_TIMEOUT - 1)) begin
                        state_d    = HALT;
                        running_d  = 1'b0;
                        error_d    = 1'b1;
                        stallRun_d = '0;
                    end else begin
                        stallRun_d = stallRun_q + 8'd1;
                    end
`endif
                end
            end
            DRAIN: begin
                cycleCnt_d = cycleCnt_q + 32'd1;
                drainCnt_d = drainCnt_q - 4'd1;
                if (drainCnt_q == 4'd1) begin
                    state_d   = HALT;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            HALT: begin
                if (bus.start) begin
                    state_d    = RUN;
                    running_d  = 1'b1;
                    done_d     = 1'b0;
                    pc_d       = RESET_PC;
                    cycleCnt_d = '0;
                    stallCnt_d = '0;
                    fetchCnt_d = '0;
`ifdef PC_FETCH_STALL_WATCHDOG_EN
                    error_d    = 1'b0;
`endif
                end
            end
            default: begin
                state_d   = IDLE;
                running_d = 1'b0;
                done_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            cycleCnt_q <= '0;
            stallCnt_q <= '0;
            fetchCnt_q <= '0;
            drainCnt_q <= '0;
`ifdef PC_FETCH_STALL_WATCHDOG_EN
            stallRun_q <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            running_q  <= running_d;
            done_q     <= done_d;
            cycleCnt_q <= cycleCnt_d;
            stallCnt_q <= stallCnt_d;
            fetchCnt_q <= fetchCnt_d;
            drainCnt_q <= drainCnt_d;
`ifdef PC_FETCH_STALL_WATCHDOG_EN
            stallRun_q <= stallRun_d;
            error_q    <= error_d;
`endif
        end
    end

    assign bus.pc        = pc_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
    assign bus.cycle_cnt = cycleCnt_q;
    assign bus.stall_cnt = stallCnt_q;
    assign bus.fetch_cnt = fetchCnt_q;
`ifdef PC_FETCH_STALL_WATCHDOG_EN
    assign bus.error     = error_q;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed scoreboard bench for pc_fetch_sequencer (RESET_PC=0, END_PC=0x10, DRAIN_CYCLES=4).
// The bench plays the CPU: next_pc is pc plus a configurable offset.
module tb_pc_fetch_sequencer;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        running;
        logic        done;
        logic        err;
        logic [31:0] cyc;
        logic [31:0] stall;
        logic [31:0] fetch;
    } expT;

    logic        clk;
    logic        rst_n;
    logic [31:0] nextPcOffset;
    int          checks;
    int          failures;
    expT         scoreboard[$];

    pc_fetch_sequencer_if bus ();

    pc_fetch_sequencer #(
        .RESET_PC      (32'h0000_0000),
        .END_PC        (32'h0000_0010),
        .DRAIN_CYCLES  (4),
        .STALL_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.next_pc = bus.pc + nextPcOffset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs, then let the DUT take the edge and settle.
    task automatic applyStimulus(input logic st, input logic pw);
        bus.start    = st;
        bus.pc_write = pw;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        expT e;
        if (scoreboard.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = scoreboard.pop_front();
        checkField({e.tag, ".pc"},      bus.pc,        e.pc);
        checkField({e.tag, ".running"}, 32'(bus.running), 32'(e.running));
        checkField({e.tag, ".done"},    32'(bus.done),    32'(e.done));
        checkField({e.tag, ".cycle"},   bus.cycle_cnt, e.cyc);
        checkField({e.tag, ".stall"},   bus.stall_cnt, e.stall);
        checkField({e.tag, ".fetch"},   bus.fetch_cnt, e.fetch);
`ifdef PC_FETCH_STALL_WATCHDOG_EN
        checkField({e.tag, ".error"},   32'(bus.error),   32'(e.err));
`endif
    endtask

    task automatic stepAndCheck(input logic st, input logic pw, input string tag,
                                input logic [31:0] pc, input logic run, input logic dn, input logic er,
                                input logic [31:0] cyc, input logic [31:0] stall, input logic [31:0] fetch);
        expT e;
        e.tag = tag; e.pc = pc; e.running = run; e.done = dn; e.err = er;
        e.cyc = cyc; e.stall = stall; e.fetch = fetch;
        scoreboard.push_back(e);
        applyStimulus(st, pw);
        checkOutput();
    endtask

    // A full run from IDLE or HALT; pokeStart pulses start once in RUN and once in DRAIN.
    task automatic cleanRun(input string t, input logic pokeStart);
        stepAndCheck(1'b1, 1'b1, {t, ".go"}, 32'h0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        for (int k = 1; k <= 4; k++)
            stepAndCheck(pokeStart && (k == 2), 1'b1, {t, ".run"}, 32'(4 * k), 1'b1, 1'b0, 1'b0,
                         32'(k), 32'd0, 32'(k));
        stepAndCheck(1'b0, 1'b1, {t, ".drainIn"}, 32'h10, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 32'd4);
        for (int k = 6; k <= 8; k++)
            stepAndCheck(pokeStart && (k == 7), 1'b0, {t, ".drain"}, 32'h10, 1'b1, 1'b0, 1'b0,
                         32'(k), 32'd0, 32'd4);
        stepAndCheck(1'b0, 1'b1, {t, ".halt"}, 32'h10, 1'b0, 1'b1, 1'b0, 32'd9, 32'd0, 32'd4);
        stepAndCheck(1'b0, 1'b1, {t, ".frozen"}, 32'h10, 1'b0, 1'b1, 1'b0, 32'd9, 32'd0, 32'd4);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        nextPcOffset = 32'd4;
        bus.start    = 1'b0;
        bus.pc_write = 1'b1;
        rst_n        = 1'b0;

        // Reset wins even with start asserted.
        applyStimulus(1'b1, 1'b1);
        stepAndCheck(1'b1, 1'b1, "reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        stepAndCheck(1'b0, 1'b1, "idle", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

        cleanRun("clean", 1'b0);
        cleanRun("restart", 1'b1);

        // Two-cycle load-use stall while pc=8.
        stepAndCheck(1'b1, 1'b1, "stall.go", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        stepAndCheck(1'b0, 1'b1, "stall.run", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 32'd1);
        stepAndCheck(1'b0, 1'b1, "stall.run", 32'h8, 1'b1, 1'b0, 1'b0, 32'd2, 32'd0, 32'd2);
        stepAndCheck(1'b0, 1'b0, "stall.hold1", 32'h8, 1'b1, 1'b0, 1'b0, 32'd3, 32'd1, 32'd2);
        stepAndCheck(1'b0, 1'b0, "stall.hold2", 32'h8, 1'b1, 1'b0, 1'b0, 32'd4, 32'd2, 32'd2);
        stepAndCheck(1'b0, 1'b1, "stall.run", 32'hC, 1'b1, 1'b0, 1'b0, 32'd5, 32'd2, 32'd3);
        stepAndCheck(1'b0, 1'b1, "stall.run", 32'h10, 1'b1, 1'b0, 1'b0, 32'd6, 32'd2, 32'd4);
        for (int k = 7; k <= 10; k++)
            stepAndCheck(1'b0, 1'b1, "stall.drain", 32'h10, 1'b1, 1'b0, 1'b0, 32'(k), 32'd2, 32'd4);
        stepAndCheck(1'b0, 1'b1, "stall.halt", 32'h10, 1'b0, 1'b1, 1'b0, 32'd11, 32'd2, 32'd4);

        // Reset while pc=8 in RUN aborts without draining.
        stepAndCheck(1'b1, 1'b1, "abort.go", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        stepAndCheck(1'b0, 1'b1, "abort.run", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 32'd1);
        stepAndCheck(1'b0, 1'b1, "abort.run", 32'h8, 1'b1, 1'b0, 1'b0, 32'd2, 32'd0, 32'd2);
        rst_n = 1'b0;
        stepAndCheck(1'b0, 1'b1, "abort.reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        stepAndCheck(1'b0, 1'b1, "abort.idle", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        cleanRun("afterAbort", 1'b0);

        // CPU returns pc+6; the low bits must be cleared.
        nextPcOffset = 32'd6;
        cleanRun("unaligned", 1'b0);
        nextPcOffset = 32'd4;

`ifdef PC_FETCH_STALL_WATCHDOG_EN
        stepAndCheck(1'b1, 1'b1, "wd.go", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        stepAndCheck(1'b0, 1'b1, "wd.run", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 32'd1);
        for (int k = 1; k < 16; k++)
            stepAndCheck(1'b0, 1'b0, "wd.stall", 32'h4, 1'b1, 1'b0, 1'b0, 32'(1 + k), 32'(k), 32'd1);
        stepAndCheck(1'b0, 1'b0, "wd.trip", 32'h4, 1'b0, 1'b0, 1'b1, 32'd17, 32'd16, 32'd1);
        stepAndCheck(1'b0, 1'b0, "wd.hold", 32'h4, 1'b0, 1'b0, 1'b1, 32'd17, 32'd16, 32'd1);

        stepAndCheck(1'b1, 1'b1, "nm.go", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        stepAndCheck(1'b0, 1'b1, "nm.run", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 32'd1);
        for (int k = 1; k <= 15; k++)
            stepAndCheck(1'b0, 1'b0, "nm.stall", 32'h4, 1'b1, 1'b0, 1'b0, 32'(1 + k), 32'(k), 32'd1);
        for (int k = 2; k <= 4; k++)
            stepAndCheck(1'b0, 1'b1, "nm.run", 32'(4 * k), 1'b1, 1'b0, 1'b0, 32'(15 + k), 32'd15, 32'(k));
        for (int k = 20; k <= 23; k++)
            stepAndCheck(1'b0, 1'b1, "nm.drain", 32'h10, 1'b1, 1'b0, 1'b0, 32'(k), 32'd15, 32'd4);
        stepAndCheck(1'b0, 1'b1, "nm.halt", 32'h10, 1'b0, 1'b1, 1'b0, 32'd24, 32'd15, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
